// File: rtl/uart_rx_cmd_if.sv
// Bundle between the UART command receiver and its host: the serial line in,
// decoded command/payload and the status pulses/counter out.
interface uart_rx_cmd_if;
    logic        rxd;
    logic [7:0]  cmd_o;
    logic [15:0] data_o;
    logic        cmd_valid_o;
    logic        frame_err_o;
    logic [7:0]  err_cnt_o;

    modport master (
        output rxd,
        input  cmd_o, data_o, cmd_valid_o, frame_err_o, err_cnt_o
    );

    modport slave (
        input  rxd,
        output cmd_o, data_o, cmd_valid_o, frame_err_o, err_cnt_o
    );
endinterface

// File: rtl/uart_rx_cmd.sv
// 8N1 UART byte receiver feeding a frame parser for A5/CMD/DH/DL/CHK command
// frames, with inter-byte timeout and a saturating rejected-frame counter.
module uart_rx_cmd #(
    parameter int BPS_PARA = 434,
    parameter int TO_BITS  = 20
) (
    input  logic          clk,
    input  logic          rstn,
    uart_rx_cmd_if.slave  bus
);
    localparam int HALF     = BPS_PARA / 2;
    localparam int CW       = $clog2(BPS_PARA + 1);
    localparam int TO_LIMIT = TO_BITS * BPS_PARA;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BPS_PARA - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_e;
    typedef enum logic [2:0] {P_HDR, P_CMD, P_DH, P_DL, P_CHK} parseState_e;

    logic rxMeta_q, rxs_q, rxsPrev_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxMeta_q  <= 1'b1;
            rxs_q     <= 1'b1;
            rxsPrev_q <= 1'b1;
        end else begin
            rxMeta_q  <= bus.rxd;
            rxs_q     <= rxMeta_q;
            rxsPrev_q <= rxs_q;
        end
    end

    rxState_e    rxState_q;
    logic [CW-1:0] baudCnt_q;
    logic [2:0]  bitCnt_q;
    logic [7:0]  shift_q;
    logic        sampleTick;
    logic        byteOk;
    logic        byteFerr;

    // Start bit is sampled at its middle; every later sample is one bit time on.
    assign sampleTick = (rxState_q == START) ? (baudCnt_q == HALF_LAST)
                                             : (baudCnt_q == BIT_LAST);
    assign byteOk     = (rxState_q == STOP) && sampleTick && rxs_q;
    assign byteFerr   = (rxState_q == STOP) && sampleTick && !rxs_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxState_q <= IDLE;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
        end else begin
            case (rxState_q)
                IDLE: begin
                    baudCnt_q <= '0;
                    if (rxsPrev_q && !rxs_q) begin
                        rxState_q <= START;
                        bitCnt_q  <= '0;
                    end
                end
                START: begin
                    if (sampleTick) begin
                        baudCnt_q <= '0;
                        rxState_q <= rxs_q ? IDLE : DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (sampleTick) begin
                        baudCnt_q <= '0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bitCnt_q  <= bitCnt_q + 1'b1;
                        if (bitCnt_q == 3'd7) rxState_q <= STOP;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (sampleTick) begin
                        baudCnt_q <= '0;
                        rxState_q <= IDLE;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                default: rxState_q <= IDLE;
            endcase
        end
    end

    parseState_e pState_q;
    logic [7:0]  cmdByte_q, dh_q, dl_q;
    logic [TW-1:0] toCnt_q;
    logic [7:0]  cmd_q;
    logic [15:0] data_q;
    logic        cmdValid_q, frameErr_q;
    logic [7:0]  errCnt_q;
    logic        timeout, chkMatch, cmdValid_d, frameErr_d;

    // toCnt_q holds cycles elapsed since the last accepted byte, so the
    // timeout pulse lands exactly TO_LIMIT cycles after that byte_ok.
    assign timeout    = (pState_q != P_HDR) && !byteOk && (toCnt_q == TO_LAST);
    assign chkMatch   = shift_q == (cmdByte_q ^ dh_q ^ dl_q);
    assign cmdValid_d = byteOk && (pState_q == P_CHK) && chkMatch;
    assign frameErr_d = byteFerr || timeout
                        || (byteOk && (pState_q == P_CHK) && !chkMatch);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pState_q   <= P_HDR;
            cmdByte_q  <= '0;
            dh_q       <= '0;
            dl_q       <= '0;
            toCnt_q    <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            cmdValid_q <= 1'b0;
            frameErr_q <= 1'b0;
            errCnt_q   <= '0;
        end else begin
            cmdValid_q <= cmdValid_d;
            frameErr_q <= frameErr_d;
            if (frameErr_d && (errCnt_q != 8'hFF)) errCnt_q <= errCnt_q + 1'b1;
            if (cmdValid_d) begin
                cmd_q  <= cmdByte_q;
                data_q <= {dh_q, dl_q};
            end

            if (byteFerr || timeout) begin
                pState_q <= P_HDR;
                toCnt_q  <= '0;
            end else if (byteOk) begin
                case (pState_q)
                    P_HDR: begin
                        if (shift_q == 8'hA5) begin
                            pState_q <= P_CMD;
                            toCnt_q  <= TW'(1);
                        end
                    end
                    P_CMD: begin
                        cmdByte_q <= shift_q;
                        pState_q  <= P_DH;
                        toCnt_q   <= TW'(1);
                    end
                    P_DH: begin
                        dh_q     <= shift_q;
                        pState_q <= P_DL;
                        toCnt_q  <= TW'(1);
                    end
                    P_DL: begin
                        dl_q     <= shift_q;
                        pState_q <= P_CHK;
                        toCnt_q  <= TW'(1);
                    end
                    default: begin
                        pState_q <= P_HDR;
                        toCnt_q  <= '0;
                    end
                endcase
            end else if (pState_q != P_HDR) begin
                toCnt_q <= toCnt_q + 1'b1;
            end
        end
    end

    assign bus.cmd_o       = cmd_q;
    assign bus.data_o      = data_q;
    assign bus.cmd_valid_o = cmdValid_q;
    assign bus.frame_err_o = frameErr_q;
    assign bus.err_cnt_o   = errCnt_q;
endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd: good/bad frames, glitches, stop-bit errors,
// timeout timing, reset mid-byte, and counter saturation on a fast instance.
module tb_uart_rx_cmd;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    uart_rx_cmd_if bus();
    uart_rx_cmd_if busF();

    uart_rx_cmd #(.BPS_PARA(100), .TO_BITS(20)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    uart_rx_cmd #(.BPS_PARA(4), .TO_BITS(20)) dutFast (
        .clk  (clk),
        .rstn (rstn),
        .bus  (busF)
    );

    int checks = 0;
    int errors = 0;
    int cycCnt = 0;
    int startCyc = 0;
    int validCnt = 0;
    int errPulseCnt = 0;
    int bothCnt = 0;
    int lastValidCyc = 0;
    int lastErrCyc = 0;
    int v0, e0, t12;

    always @(posedge clk) cycCnt <= cycCnt + 1;

    always @(negedge clk) begin
        if (bus.cmd_valid_o === 1'b1) begin
            validCnt     = validCnt + 1;
            lastValidCyc = cycCnt;
        end
        if (bus.frame_err_o === 1'b1) begin
            errPulseCnt = errPulseCnt + 1;
            lastErrCyc  = cycCnt;
        end
        if (bus.cmd_valid_o === 1'b1 && bus.frame_err_o === 1'b1) bothCnt = bothCnt + 1;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic driveLine(input bit sel, input logic v);
        if (sel) busF.rxd = v;
        else     bus.rxd  = v;
    endtask

    // One 8N1 byte on the chosen line; a bad stop bit is followed by an idle gap
    // so the receiver sees a fresh falling edge for the next byte.
    task automatic applyStimulus(input bit sel, input logic [7:0] b, input logic stopBit);
        int bps;
        bps = sel ? 4 : 100;
        @(negedge clk);
        startCyc = cycCnt;
        driveLine(sel, 1'b0);
        repeat (bps) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            driveLine(sel, b[i]);
            repeat (bps) @(negedge clk);
        end
        driveLine(sel, stopBit);
        repeat (bps - 1) @(negedge clk);
        driveLine(sel, 1'b1);
        if (!stopBit) repeat (2 * bps) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] c, input logic [7:0] dh,
                             input logic [7:0] dl, input logic [7:0] chk);
        applyStimulus(0, 8'hA5, 1'b1);
        applyStimulus(0, c, 1'b1);
        applyStimulus(0, dh, 1'b1);
        applyStimulus(0, dl, 1'b1);
        applyStimulus(0, chk, 1'b1);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        bus.rxd  = 1'b1;
        busF.rxd = 1'b1;
        rstn     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd", bus.cmd_o, 0);
        checkOutput("rst_data", bus.data_o, 0);
        checkOutput("rst_valid", bus.cmd_valid_o, 0);
        checkOutput("rst_ferr", bus.frame_err_o, 0);
        checkOutput("rst_errcnt", bus.err_cnt_o, 0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);

        // Good frame; valid pulse one cycle after the checksum stop-bit sample.
        v0 = validCnt; e0 = errPulseCnt;
        sendFrame(8'h12, 8'h34, 8'h56, 8'h70);
        checkOutput("good_valid_cnt", validCnt - v0, 1);
        checkOutput("good_cmd", bus.cmd_o, 32'h12);
        checkOutput("good_data", bus.data_o, 32'h3456);
        checkOutput("good_errcnt", bus.err_cnt_o, 0);
        checkOutput("good_latency", lastValidCyc - startCyc, 953);

        // Bad checksum.
        v0 = validCnt; e0 = errPulseCnt;
        sendFrame(8'h12, 8'h34, 8'h56, 8'h71);
        checkOutput("badchk_err_cnt", errPulseCnt - e0, 1);
        checkOutput("badchk_valid_cnt", validCnt - v0, 0);
        checkOutput("badchk_errcnt", bus.err_cnt_o, 1);
        checkOutput("badchk_cmd_hold", bus.cmd_o, 32'h12);
        checkOutput("badchk_data_hold", bus.data_o, 32'h3456);

        // Short glitch and a non-header byte are both ignored silently.
        v0 = validCnt; e0 = errPulseCnt;
        @(negedge clk);
        bus.rxd = 1'b0;
        repeat (30) @(negedge clk);
        bus.rxd = 1'b1;
        repeat (200) @(negedge clk);
        applyStimulus(0, 8'h00, 1'b1);
        sendFrame(8'h01, 8'h00, 8'h02, 8'h03);
        checkOutput("glitch_err_cnt", errPulseCnt - e0, 0);
        checkOutput("glitch_valid_cnt", validCnt - v0, 1);
        checkOutput("glitch_cmd", bus.cmd_o, 32'h01);
        checkOutput("glitch_data", bus.data_o, 32'h0002);

        // Stop-bit error mid-frame, then a good frame.
        v0 = validCnt; e0 = errPulseCnt;
        applyStimulus(0, 8'hA5, 1'b1);
        applyStimulus(0, 8'h12, 1'b1);
        applyStimulus(0, 8'h34, 1'b0);
        sendFrame(8'hAB, 8'hCD, 8'hEF, 8'h89);
        checkOutput("ferr_err_cnt", errPulseCnt - e0, 1);
        checkOutput("ferr_valid_cnt", validCnt - v0, 1);
        checkOutput("ferr_cmd", bus.cmd_o, 32'hAB);
        checkOutput("ferr_data", bus.data_o, 32'hCDEF);
        checkOutput("ferr_errcnt", bus.err_cnt_o, 2);

        // Inter-byte timeout: 2000 cycles after the 0x12 byte_ok.
        v0 = validCnt; e0 = errPulseCnt;
        applyStimulus(0, 8'hA5, 1'b1);
        applyStimulus(0, 8'h12, 1'b1);
        t12 = startCyc;
        repeat (2200) @(negedge clk);
        checkOutput("to_err_cnt", errPulseCnt - e0, 1);
        checkOutput("to_time", lastErrCyc - t12, 2952);
        checkOutput("to_errcnt", bus.err_cnt_o, 3);
        checkOutput("to_valid_cnt", validCnt - v0, 0);

        // Reset asserted in the middle of a byte's data bits.
        e0 = errPulseCnt;
        fork
            applyStimulus(0, 8'hA5, 1'b1);
            begin
                repeat (400) @(negedge clk);
                rstn = 1'b0;
                repeat (5) @(negedge clk);
                checkOutput("midrst_cmd", bus.cmd_o, 0);
                checkOutput("midrst_data", bus.data_o, 0);
                checkOutput("midrst_valid", bus.cmd_valid_o, 0);
                checkOutput("midrst_ferr", bus.frame_err_o, 0);
                checkOutput("midrst_errcnt", bus.err_cnt_o, 0);
                rstn = 1'b1;
            end
        join
        repeat (1000) @(negedge clk);
        v0 = validCnt;
        sendFrame(8'h5A, 8'h12, 8'h34, 8'h7C);
        checkOutput("postrst_valid_cnt", validCnt - v0, 1);
        checkOutput("postrst_cmd", bus.cmd_o, 32'h5A);
        checkOutput("postrst_data", bus.data_o, 32'h1234);
        checkOutput("postrst_errcnt", bus.err_cnt_o, 0);
        checkOutput("postrst_err_cnt", errPulseCnt - e0, 0);

        // Error counter saturation on the fast instance.
        for (int i = 0; i < 200; i++) applyStimulus(1, 8'h00, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("sat_200", busF.err_cnt_o, 200);
        for (int i = 0; i < 60; i++) applyStimulus(1, 8'h00, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("sat_260", busF.err_cnt_o, 255);

        checkOutput("valid_ferr_excl", bothCnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
